// File: rtl/net_toggle_monitor_pkg.sv
// -----------------------------------------------------------------------------
// net_toggle_monitor_pkg
//   Shared types and helpers for the net toggle monitor.
//   - ntm_state_e : drain FSM state (IDLE / DRAIN), also exported on the
//                   debug state port of the top.
//   - clog2_min1  : ceil(log2(n)) clamped to at least 1 bit, so that WIDTH=1
//                   or WINDOW=1 still produce legal vector widths.
//   - sat_inc     : increment that sticks at a supplied maximum.
// -----------------------------------------------------------------------------
package net_toggle_monitor_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } ntm_state_e;

   // Counters up to 32 bits wide are handled by sat_inc.
   localparam int SAT_W = 32;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cur,
                                                input logic [SAT_W-1:0] max_val);
      return (cur >= max_val) ? cur : cur + 32'd1;
   endfunction

endpackage

// File: rtl/ntm_counter_bank.sv
// -----------------------------------------------------------------------------
// ntm_counter_bank
//   WIDTH saturating live toggle counters plus a snapshot register per net.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset (clears all registers)
//     clear_i     : live counters go to 0 next cycle (overrides this cycle's toggles)
//     capture_i   : snapshot <= live count including this cycle's toggles
//     toggle_i    : one bit per net, 1 = count a toggle this cycle
//     rd_idx_i    : snapshot read index
//     rd_count_o  : snapshot value at rd_idx_i
// -----------------------------------------------------------------------------
module ntm_counter_bank
   import net_toggle_monitor_pkg::*;
#(
   parameter int WIDTH = 34,
   parameter int CNT_W = 16,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             capture_i,
   input  logic [WIDTH-1:0] toggle_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [CNT_W-1:0] rd_count_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [CNT_W-1:0] cnt_inc[WIDTH];
   logic [CNT_W-1:0] snap_q [WIDTH];

   // cnt_inc is the live count with this cycle's toggle folded in; the
   // snapshot takes it so the closing sample is part of the window.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         cnt_inc[i] = toggle_i[i] ? CNT_W'(sat_inc(32'(cnt_q[i]), 32'(CNT_MAX)))
                                  : cnt_q[i];
         cnt_d[i]   = clear_i ? '0 : cnt_inc[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
            if (capture_i) begin
               snap_q[i] <= cnt_inc[i];
            end
         end
      end
   end

   assign rd_count_o = snap_q[rd_idx_i];

endmodule

// File: rtl/net_toggle_monitor.sv
// -----------------------------------------------------------------------------
// net_toggle_monitor
//   Counts per-net toggles over windows of WINDOW enabled cycles, then streams
//   one {idx,count} record per net to the power/thermal model.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     en           : sampling enable; low cycles are skipped and break edge history
//     nets         : WIDTH monitored net values
//     out_valid    : record valid
//     out_ready    : consumer ready
//     out_idx      : net index of the record
//     out_count    : toggles of that net in the closed window (0 when not valid)
//     out_last     : record is for net WIDTH-1
//     overrun      : sticky, a window closed while a drain was still in progress
//     dbg_state_o  : drain FSM state
// -----------------------------------------------------------------------------
module net_toggle_monitor
   import net_toggle_monitor_pkg::*;
#(
   parameter  int WIDTH  = 34,
   parameter  int CNT_W  = 16,
   parameter  int WINDOW = 1024,
   localparam int IDX_W  = clog2_min1(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] nets,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_count,
   output logic             out_last,
   output logic             overrun,
   output ntm_state_e       dbg_state_o
);

   localparam int               WIN_W    = clog2_min1(WINDOW);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   // Sampling state
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic [WIN_W-1:0] win_q, win_d;

   // Drain FSM state and registered outputs
   ntm_state_e       state_q;
   logic             out_valid_q;
   logic [IDX_W-1:0] out_idx_q;
   logic             out_last_q;
   logic             overrun_q;

   logic [WIDTH-1:0] toggle;
   logic             win_close;
   logic             handshake;
   logic             drain_free;
   logic             capture;
   logic [CNT_W-1:0] snap_count;

   // Edges are only counted between two consecutive enabled samples.
   assign toggle    = (en && prev_valid_q) ? (nets ^ prev_q) : '0;
   assign win_close = en && (win_q == WIN_LAST);

   always_comb begin
      prev_d       = prev_q;
      prev_valid_d = 1'b0;
      win_d        = win_q;
      if (en) begin
         prev_d       = nets;
         prev_valid_d = 1'b1;
         win_d        = win_close ? '0 : win_q + WIN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         win_q        <= '0;
      end else begin
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         win_q        <= win_d;
      end
   end

   // Output handshake: a record transfers on a cycle where out_valid and
   // out_ready are both high. Once out_valid is raised it stays high, and
   // out_idx/out_count/out_last stay stable, until that transfer happens.
   assign handshake  = out_valid_q && out_ready;
   // A close coinciding with the final transfer is treated like a close in IDLE.
   assign drain_free = (state_q == ST_IDLE) || (handshake && out_last_q);
   assign capture    = win_close && drain_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (win_close && !drain_free) begin
            overrun_q <= 1'b1;
         end
         if (capture) begin
            state_q     <= ST_DRAIN;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_last_q  <= (IDX_LAST == '0);
         end else if (handshake) begin
            if (out_last_q) begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               out_idx_q   <= '0;
               out_last_q  <= 1'b0;
            end else begin
               out_idx_q  <= out_idx_q + IDX_W'(1);
               out_last_q <= ((out_idx_q + IDX_W'(1)) == IDX_LAST);
            end
         end
      end
   end

   ntm_counter_bank #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (win_close),
      .capture_i  (capture),
      .toggle_i   (toggle),
      .rd_idx_i   (out_idx_q),
      .rd_count_o (snap_count)
   );

   assign out_valid   = out_valid_q;
   assign out_idx     = out_idx_q;
   assign out_count   = out_valid_q ? snap_count : '0;
   assign out_last    = out_last_q;
   assign overrun     = overrun_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_net_toggle_monitor.sv
`timescale 1ns/1ps
module tb_net_toggle_monitor;
  import net_toggle_monitor_pkg::*;

  localparam int TW   = 4;
  localparam int TWIN = 8;
  localparam int CW_A = 16;
  localparam int CW_B = 2;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [TW-1:0] nets;
  logic          out_ready;

  always #5 clk = ~clk;

  logic        va, vb, la, lb, oa, ob;
  logic [1:0]  ia, ib;
  logic [15:0] ca;
  logic [1:0]  cb;
  ntm_state_e  sa, sb;

  net_toggle_monitor #(.WIDTH(TW), .CNT_W(CW_A), .WINDOW(TWIN)) dut_a (
    .clk(clk), .rst(rst), .en(en), .nets(nets),
    .out_valid(va), .out_ready(out_ready), .out_idx(ia), .out_count(ca),
    .out_last(la), .overrun(oa), .dbg_state_o(sa)
  );

  net_toggle_monitor #(.WIDTH(TW), .CNT_W(CW_B), .WINDOW(TWIN)) dut_b (
    .clk(clk), .rst(rst), .en(en), .nets(nets),
    .out_valid(vb), .out_ready(out_ready), .out_idx(ib), .out_count(cb),
    .out_last(lb), .overrun(ob), .dbg_state_o(sb)
  );

  // ---------------- scoreboard / model ----------------
  int vectors     = 0;
  int miscompares = 0;

  // exp_q[k] holds the records still to be delivered by instance k (a = 0, b = 1)
  logic [15:0]   exp_q[2][$];
  int            live[2][TW];
  int            last_snap[2][TW];
  bit            ovr_m[2];
  int            cmax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  int            wcnt;
  logic [TW-1:0] prev_m;
  bit            pv_m;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the reference: records are consumed first, then this
  // cycle's sample is accounted and a window may close.
  task automatic model_step();
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        ovr_m[k] = 1'b0;
        for (int i = 0; i < TW; i++) live[k][i] = 0;
      end
      wcnt   = 0;
      pv_m   = 1'b0;
      prev_m = '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (exp_q[k].size() != 0 && out_ready) void'(exp_q[k].pop_front());
      if (en) begin
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < TW; i++)
            if (pv_m && (nets[i] != prev_m[i]) && live[k][i] < cmax[k]) live[k][i]++;
        if (wcnt == TWIN - 1) begin
          for (int k = 0; k < 2; k++) begin
            if (exp_q[k].size() == 0) begin
              for (int i = 0; i < TW; i++) begin
                exp_q[k].push_back(16'(live[k][i]));
                last_snap[k][i] = live[k][i];
              end
            end else begin
              ovr_m[k] = 1'b1;
            end
            for (int i = 0; i < TW; i++) live[k][i] = 0;
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
        prev_m = nets;
        pv_m   = 1'b1;
      end else begin
        pv_m = 1'b0;
      end
    end
  endtask

  task automatic cmp_inst(input string n, input int k, input logic v, input logic [1:0] idx,
                          input logic [15:0] cnt, input logic last, input logic ovr,
                          input ntm_state_e st);
    bit ev;
    ev = (exp_q[k].size() != 0);
    check({n, "_valid"}, 32'(v), 32'(ev));
    check({n, "_overrun"}, 32'(ovr), 32'(ovr_m[k]));
    check({n, "_draining"}, 32'(st == ST_DRAIN), 32'(ev));
    if (ev) begin
      check({n, "_idx"}, 32'(idx), 32'(TW - exp_q[k].size()));
      check({n, "_count"}, 32'(cnt), 32'(exp_q[k][0]));
      check({n, "_last"}, 32'(last), 32'(exp_q[k].size() == 1));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("a", 0, va, ia, ca, la, oa, sa);
      cmp_inst("b", 1, vb, ib, {14'd0, cb}, lb, ob, sb);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic e, input logic [TW-1:0] n, input logic rdy);
    rst       = r;
    en        = e;
    nets      = n;
    out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pin_snap(input string name, input int k, input int e0, input int e1,
                          input int e2, input int e3);
    int e[TW];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < TW; i++) check($sformatf("%s[%0d]", name, i), 32'(last_snap[k][i]), 32'(e[i]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b0; nets = '0; out_ready = 1'b0;
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    chk_en = 1'b1;
    check("rst_valid", 32'(va), 0);
    check("rst_idx", 32'(ia), 0);
    check("rst_count", 32'(ca), 0);
    check("rst_last", 32'(la), 0);
    check("rst_overrun", 32'(oa), 0);

    // Two windows with bit0 toggling every sample, consumer always ready
    for (int c = 0; c < 16; c++) begin
      cyc(0, 1, TW'(c & 1), 1);
      if (c == 7) begin
        check("t1_latency_valid", 32'(va), 1);
        check("t1_first_count", 32'(ca), 7);
        pin_snap("t1_snap_a", 0, 7, 0, 0, 0);
        pin_snap("t1_snap_b", 1, 3, 0, 0, 0);
      end
    end
    pin_snap("t2_snap_a", 0, 8, 0, 0, 0);
    pin_snap("t2_snap_b", 1, 3, 0, 0, 0);

    // Consumer stalls 5 cycles mid-drain; sampling paused meanwhile
    for (int c = 16; c < 41; c++) begin
      bit stall;
      stall = (c >= 25 && c <= 29);
      cyc(0, !stall, TW'(c & 1), !stall);
    end

    // Consumer stalls longer than a window: overrun, first window still drained
    cyc(1, 0, '0, 1);
    for (int c = 0; c < 8; c++) cyc(0, 1, TW'((c & 1) << 2), 0);
    for (int c = 0; c < 8; c++) cyc(0, 1, 4'b0100, 0);
    check("t4_overrun", 32'(oa), 1);
    check("t4_overrun_model", 32'(ovr_m[0]), 1);
    pin_snap("t4_snap_a", 0, 0, 0, 7, 0);
    cyc(0, 0, 4'b0100, 1);
    cyc(0, 0, 4'b0100, 1);
    check("t4_idx2", 32'(ia), 2);
    check("t4_count2", 32'(ca), 7);
    cyc(0, 0, 4'b0100, 1);
    cyc(0, 0, 4'b0100, 1);
    check("t4_overrun_sticky", 32'(oa), 1);

    // Reset in the middle of a drain
    cyc(1, 0, '0, 1);
    check("t6_overrun_cleared", 32'(oa), 0);
    for (int c = 0; c < 8; c++) cyc(0, 1, TW'((c & 1) << 1), 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    check("t6_idx2", 32'(ia), 2);
    cyc(1, 0, '0, 1);
    check("t6_rst_valid", 32'(va), 0);
    check("t6_rst_count", 32'(ca), 0);
    check("t6_rst_overrun", 32'(oa), 0);

    // Enable gap with nets changing: the edge across the gap is not counted
    for (int c = 0; c < 3; c++) cyc(0, 1, 4'b0000, 1);
    cyc(0, 0, 4'b1000, 1);
    cyc(0, 0, 4'b0000, 1);
    cyc(0, 0, 4'b1000, 1);
    for (int c = 0; c < 5; c++) cyc(0, 1, 4'b1000, 1);
    pin_snap("t6_gap_snap", 0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) cyc(0, 1, 4'b1000, 1);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
          TW'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 12; c++) cyc(0, 0, '0, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
